// File: rtl/tc_sram_hs.sv
// tc_sram_hs: multi-port SRAM model with request/grant handshake, fixed read
// latency and a per-port response queue with ready/valid back-pressure.
// Optional feature: define TC_SRAM_HS_ADDR_CHECK_EN to flag addresses
// >= NumWords with rerr_o and block their writes.
module tc_sram_hs #(
    parameter int unsigned NumWords  = 1024,
    parameter int unsigned DataWidth = 128,
    parameter int unsigned ByteWidth = 8,
    parameter int unsigned NumPorts  = 2,
    parameter int unsigned Latency   = 1,
    parameter int unsigned RespDepth = Latency + 1,
    parameter string       SimInit   = "none",
    parameter int unsigned AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1,
    parameter int unsigned BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [NumPorts-1:0]                 req_i,
    output logic [NumPorts-1:0]                 gnt_o,
    input  logic [NumPorts-1:0]                 we_i,
    input  logic [NumPorts-1:0][AddrWidth-1:0]  addr_i,
    input  logic [NumPorts-1:0][DataWidth-1:0]  wdata_i,
    input  logic [NumPorts-1:0][BeWidth-1:0]    be_i,
    output logic [NumPorts-1:0]                 rvalid_o,
    input  logic [NumPorts-1:0]                 rready_i,
    output logic [NumPorts-1:0][DataWidth-1:0]  rdata_o,
    output logic [NumPorts-1:0]                 rerr_o
);

    localparam int unsigned PtrW = (RespDepth > 1) ? $clog2(RespDepth) : 1;
    localparam int unsigned CntW = $clog2(RespDepth + 1);
    localparam int unsigned TmrW = (Latency > 1) ? $clog2(Latency) : 1;

    localparam bit InitZeros  = (SimInit == "zeros");
    localparam bit InitOnes   = (SimInit == "ones");
    localparam bit InitRandom = (SimInit == "random");

    logic [DataWidth-1:0] mem_q [NumWords];

    // Response queue entries carry their own countdown; the head is only
    // presented once its countdown reaches zero, which enforces Latency.
    logic [DataWidth-1:0] q_data [NumPorts][RespDepth];
    logic [TmrW-1:0]      q_tmr  [NumPorts][RespDepth];
    logic [PtrW-1:0]      wptr_q [NumPorts];
    logic [PtrW-1:0]      rptr_q [NumPorts];
    logic [CntW-1:0]      cnt_q  [NumPorts];

    logic [NumPorts-1:0]  acc;
    logic [NumPorts-1:0]  cons;
    logic [NumPorts-1:0]  wr_en;
    logic [DataWidth-1:0] rsp_word [NumPorts];

`ifdef TC_SRAM_HS_ADDR_CHECK_EN
    logic                 q_err  [NumPorts][RespDepth];
    logic [NumPorts-1:0]  addr_bad;
`endif

    // Grant, response presentation and per-port accept/consume strobes
    always_comb begin
        gnt_o    = '0;
        rvalid_o = '0;
        rdata_o  = '0;
        rerr_o   = '0;
        acc      = '0;
        cons     = '0;
        wr_en    = '0;
`ifdef TC_SRAM_HS_ADDR_CHECK_EN
        addr_bad = '0;
`endif
        for (int p = 0; p < NumPorts; p++) begin
            rsp_word[p] = '0;
            gnt_o[p]    = req_i[p] & ~rst_i & (cnt_q[p] < CntW'(RespDepth));
            acc[p]      = gnt_o[p];
            rvalid_o[p] = (cnt_q[p] != '0) && (q_tmr[p][rptr_q[p]] == '0);
            cons[p]     = rvalid_o[p] & rready_i[p];
            if (rvalid_o[p]) begin
                rdata_o[p] = q_data[p][rptr_q[p]];
`ifdef TC_SRAM_HS_ADDR_CHECK_EN
                rerr_o[p]  = q_err[p][rptr_q[p]];
`endif
            end
`ifdef TC_SRAM_HS_ADDR_CHECK_EN
            addr_bad[p] = 32'(addr_i[p]) >= NumWords;
            wr_en[p]    = acc[p] & we_i[p] & ~addr_bad[p];
            if (!we_i[p] && !addr_bad[p]) begin
                rsp_word[p] = mem_q[addr_i[p]];
            end
`else
            wr_en[p]    = acc[p] & we_i[p];
            if (!we_i[p]) begin
                rsp_word[p] = mem_q[addr_i[p]];
            end
`endif
        end
    end

    // Response queues: countdown aging, enqueue on accept, dequeue on consume
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int p = 0; p < NumPorts; p++) begin
                wptr_q[p] <= '0;
                rptr_q[p] <= '0;
                cnt_q[p]  <= '0;
                for (int e = 0; e < RespDepth; e++) begin
                    q_data[p][e] <= '0;
                    q_tmr[p][e]  <= '0;
`ifdef TC_SRAM_HS_ADDR_CHECK_EN
                    q_err[p][e]  <= 1'b0;
`endif
                end
            end
        end else begin
            for (int p = 0; p < NumPorts; p++) begin
                for (int e = 0; e < RespDepth; e++) begin
                    if (q_tmr[p][e] != '0) begin
                        q_tmr[p][e] <= q_tmr[p][e] - TmrW'(1);
                    end
                end
                if (acc[p]) begin
                    q_data[p][wptr_q[p]] <= rsp_word[p];
                    q_tmr[p][wptr_q[p]]  <= TmrW'(Latency - 1);
`ifdef TC_SRAM_HS_ADDR_CHECK_EN
                    q_err[p][wptr_q[p]]  <= addr_bad[p];
`endif
                    wptr_q[p] <= (wptr_q[p] == PtrW'(RespDepth - 1)) ? '0 : wptr_q[p] + PtrW'(1);
                end
                if (cons[p]) begin
                    rptr_q[p] <= (rptr_q[p] == PtrW'(RespDepth - 1)) ? '0 : rptr_q[p] + PtrW'(1);
                end
                if (acc[p] && !cons[p]) begin
                    cnt_q[p] <= cnt_q[p] + CntW'(1);
                end else if (!acc[p] && cons[p]) begin
                    cnt_q[p] <= cnt_q[p] - CntW'(1);
                end
            end
        end
    end

    // Array: load per SimInit in reset; byte-lane writes, higher port applied last
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int w = 0; w < NumWords; w++) begin
                if (InitZeros) begin
                    mem_q[w] <= '0;
                end else if (InitOnes) begin
                    mem_q[w] <= '1;
                end else if (InitRandom) begin
                    for (int b = 0; b < DataWidth; b++) begin
                        mem_q[w][b] <= 1'($urandom());
                    end
                end
            end
        end else begin
            for (int p = 0; p < NumPorts; p++) begin
                if (wr_en[p]) begin
                    for (int b = 0; b < DataWidth; b++) begin
                        if (be_i[p][b / ByteWidth]) begin
                            mem_q[addr_i[p]][b] <= wdata_i[p][b];
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_tc_sram_hs.sv
// Self-checking bench for tc_sram_hs (NumWords=1000, 32-bit data, 2 ports,
// Latency=2, RespDepth=3). A negedge monitor keeps a reference array and a
// per-port response scoreboard; directed sequences cover latency, back-pressure,
// write collisions, byte enables and mid-operation reset.
module tb_tc_sram_hs;

    localparam int unsigned NW = 1000;
    localparam int unsigned DW = 32;
    localparam int unsigned NP = 2;
    localparam int unsigned AW = 10;
    localparam int unsigned BW = 4;
    localparam int unsigned DEPTH = 3;
    localparam int unsigned LAT = 2;

    typedef struct {
        logic [DW-1:0] data;
        logic          err;
        int            cyc;
    } exp_t;

    logic                    clk;
    logic                    rst;
    logic [NP-1:0]           req;
    logic [NP-1:0]           gnt;
    logic [NP-1:0]           we;
    logic [NP-1:0][AW-1:0]   addr;
    logic [NP-1:0][DW-1:0]   wdata;
    logic [NP-1:0][BW-1:0]   be;
    logic [NP-1:0]           rvalid;
    logic [NP-1:0]           rready;
    logic [NP-1:0][DW-1:0]   rdata;
    logic [NP-1:0]           rerr;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [DW-1:0] mmem [NW];
    int            mcnt [NP];
    exp_t          sb [NP][$];

    tc_sram_hs #(
        .NumWords (NW),
        .DataWidth(DW),
        .ByteWidth(8),
        .NumPorts (NP),
        .Latency  (LAT),
        .RespDepth(DEPTH),
        .SimInit  ("zeros")
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .req_i   (req),
        .gnt_o   (gnt),
        .we_i    (we),
        .addr_i  (addr),
        .wdata_i (wdata),
        .be_i    (be),
        .rvalid_o(rvalid),
        .rready_i(rready),
        .rdata_o (rdata),
        .rerr_o  (rerr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic bit in_range(input logic [AW-1:0] a);
`ifdef TC_SRAM_HS_ADDR_CHECK_EN
        return 32'(a) < NW;
`else
        return 1'b1;
`endif
    endfunction

    // Reference model: predicts the upcoming rising edge from stable inputs
    always @(negedge clk) begin
        if (rst) begin
            for (int p = 0; p < NP; p++) begin
                sb[p].delete();
                mcnt[p] = 0;
            end
            for (int w = 0; w < NW; w++) mmem[w] = '0;
            check_eq("rst_gnt", 64'(gnt), 64'(0));
            check_eq("rst_rvalid", 64'(rvalid), 64'(0));
            check_eq("rst_rdata", 64'(rdata), 64'(0));
            check_eq("rst_rerr", 64'(rerr), 64'(0));
        end else begin
            bit [NP-1:0] a;
            bit [NP-1:0] c;
            a = '0;
            c = '0;
            for (int p = 0; p < NP; p++) begin
                check_eq("gnt", 64'(gnt[p]), 64'(req[p] && (mcnt[p] < DEPTH)));
                a[p] = req[p] & gnt[p];
                if (rvalid[p]) begin
                    if (sb[p].size() == 0) begin
                        check_eq("unexpected_rvalid", 64'(1), 64'(0));
                    end else begin
                        exp_t e;
                        e = sb[p][0];
                        check_eq("rdata", 64'(rdata[p]), 64'(e.data));
                        check_eq("rerr", 64'(rerr[p]), 64'(e.err));
                        check_eq("min_latency", 64'(cyc - e.cyc >= LAT), 64'(1));
                        if (rready[p]) begin
                            void'(sb[p].pop_front());
                            c[p] = 1'b1;
                        end
                    end
                end else begin
                    check_eq("rdata_idle", 64'(rdata[p]), 64'(0));
                end
            end
            for (int p = 0; p < NP; p++) begin
                if (a[p]) begin
                    exp_t e;
                    e.cyc  = cyc;
                    e.err  = !in_range(addr[p]);
                    e.data = (we[p] || e.err) ? '0 : mmem[addr[p]];
                    sb[p].push_back(e);
                end
            end
            for (int p = 0; p < NP; p++) begin
                if (a[p] && we[p] && in_range(addr[p])) begin
                    for (int b = 0; b < DW; b++) begin
                        if (be[p][b / 8]) mmem[addr[p]][b] = wdata[p][b];
                    end
                end
                mcnt[p] = mcnt[p] + int'(a[p]) - int'(c[p]);
            end
        end
        cyc++;
    end

    // Issue one request on port p; returns 1 time unit after the accepting edge
    task automatic do_req(input int p, input bit w, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [BW-1:0] b);
        int n;
        n = 0;
        req[p] = 1'b1; we[p] = w; addr[p] = a; wdata[p] = d; be[p] = b;
        #1;
        while (!gnt[p]) begin
            @(posedge clk); #2;
            n++;
            if (n > 40) begin
                check_eq("grant_timeout", 64'(0), 64'(1));
                break;
            end
        end
        @(posedge clk); #1;
        req[p] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Hold a read request on port 0 for n cycles and count grants seen
    task automatic hold_count(input int n, input logic [AW-1:0] base, output int ng);
        ng = 0;
        req[0] = 1'b1; we[0] = 1'b0; addr[0] = base;
        for (int i = 0; i < n; i++) begin
            #1;
            if (gnt[0]) ng++;
            @(posedge clk); #1;
            addr[0] = base + AW'(ng);
        end
    endtask

    initial begin
        int ng;
        int n;
        rst = 1'b1; req = '0; we = '0; addr = '0; wdata = '0; be = '0; rready = '1;
        repeat (3) @(posedge clk);
        #1;
        req[0] = 1'b1; addr[0] = '0;
        #1;
        check_eq("gnt_in_reset", 64'(gnt[0]), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check_eq("first_gnt_after_reset", 64'(gnt[0]), 64'(1));
        @(posedge clk); #1;
        req[0] = 1'b0;
        idle(4);

        // Write then read addr 5: read response exactly LAT cycles after grant
        do_req(0, 1'b1, AW'(5), 32'hAAAA_AAAA, 4'hF);
        idle(4);
        do_req(0, 1'b0, AW'(5), '0, 4'hF);
        check_eq("lat_not_early", 64'(rvalid[0]), 64'(0));
        @(posedge clk); #1;
        check_eq("lat_exact_rvalid", 64'(rvalid[0]), 64'(1));
        check_eq("lat_exact_rdata", 64'(rdata[0]), 64'(32'hAAAA_AAAA));
        check_eq("lat_exact_rerr", 64'(rerr[0]), 64'(0));
        idle(3);

        // Back-pressure: exactly DEPTH grants, then resume on rready
        do_req(0, 1'b1, AW'(10), 32'h0000_0A0A, 4'hF);
        do_req(0, 1'b1, AW'(11), 32'h0000_0B0B, 4'hF);
        do_req(0, 1'b1, AW'(12), 32'h0000_0C0C, 4'hF);
        idle(4);
        rready[0] = 1'b0;
        hold_count(6, AW'(10), ng);
        check_eq("backpressure_grants", 64'(ng), 64'(DEPTH));
        #1;
        check_eq("backpressure_gnt_low", 64'(gnt[0]), 64'(0));
        rready[0] = 1'b1;
        n = 0;
        while (!gnt[0] && n < 10) begin
            @(posedge clk); #2;
            n++;
        end
        check_eq("grant_resume", 64'(gnt[0]), 64'(1));
        @(posedge clk); #1;
        req[0] = 1'b0;
        idle(6);

        // Same-cycle writes to addr 3: port 1 wins
        req = 2'b11; we = 2'b11; addr[0] = AW'(3); addr[1] = AW'(3);
        wdata[0] = 32'h1111_1111; wdata[1] = 32'h2222_2222; be[0] = 4'hF; be[1] = 4'hF;
        #1;
        check_eq("collide_gnt", 64'(gnt), 64'(2'b11));
        @(posedge clk); #1;
        req = '0;
        do_req(0, 1'b0, AW'(3), '0, 4'h0);
        do_req(1, 1'b0, AW'(3), '0, 4'h0);
        idle(4);

        // Byte enables: only lane 0 cleared; be=0 changes nothing
        do_req(1, 1'b1, AW'(20), 32'hFFFF_FFFF, 4'hF);
        do_req(1, 1'b1, AW'(20), 32'h0000_0000, 4'h1);
        do_req(1, 1'b1, AW'(20), 32'h1234_5678, 4'h0);
        do_req(1, 1'b0, AW'(20), '0, 4'h0);
        idle(4);

        // Mid-operation reset discards queued responses
        rready[0] = 1'b0;
        do_req(0, 1'b0, AW'(3), '0, 4'h0);
        do_req(0, 1'b0, AW'(5), '0, 4'h0);
        idle(3);
        check_eq("queued_rvalid", 64'(rvalid[0]), 64'(1));
        rst = 1'b1;
        #1;
        check_eq("rst_async_rvalid", 64'(rvalid), 64'(0));
        check_eq("rst_async_rdata", 64'(rdata), 64'(0));
        idle(2);
        rst = 1'b0;
        rready[0] = 1'b1;
        idle(6);
        rready[0] = 1'b0;
        hold_count(5, AW'(3), ng);
        check_eq("post_reset_grants", 64'(ng), 64'(DEPTH));
        req[0] = 1'b0;
        rready[0] = 1'b1;
        idle(6);

`ifdef TC_SRAM_HS_ADDR_CHECK_EN
        // Out-of-range access: error response, no array change
        do_req(0, 1'b1, AW'(1000), 32'h5555_5555, 4'hF);
        do_req(0, 1'b0, AW'(1000), '0, 4'h0);
        do_req(0, 1'b0, AW'(0), '0, 4'h0);
        idle(5);
`endif

        // Full throughput on both ports
        ng = 0;
        req = 2'b11; we = '0;
        for (int i = 0; i < 10; i++) begin
            addr[0] = AW'(i); addr[1] = AW'(20 - i);
            #1;
            if (gnt == 2'b11) ng++;
            @(posedge clk); #1;
        end
        req = '0;
        check_eq("throughput", 64'(ng), 64'(10));
        idle(4);

        // Random traffic with random back-pressure
        for (int i = 0; i < 80; i++) begin
            for (int p = 0; p < NP; p++) begin
                req[p]    = 1'($urandom_range(0, 1));
                we[p]     = 1'($urandom_range(0, 1));
                addr[p]   = AW'($urandom_range(0, 15));
                wdata[p]  = $urandom();
                be[p]     = BW'($urandom_range(0, 15));
                rready[p] = ($urandom_range(0, 3) != 0);
            end
            @(posedge clk); #1;
        end

        // Drain
        req = '0;
        rready = '1;
        n = 0;
        while ((sb[0].size() != 0 || sb[1].size() != 0) && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        idle(2);
        check_eq("drain_empty", 64'(sb[0].size() + sb[1].size()), 64'(0));
        check_eq("drain_rvalid", 64'(rvalid), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/tc_sram_hs.md
TC_SRAM_HS -- requirements
Module: tc_sram_hs

Interface
REQ-001 SHALL have parameter NumWords, default 1024: words in the array; minimum 1.
REQ-002 SHALL have parameter DataWidth, default 128: data width in bits; minimum 1.
REQ-003 SHALL have parameter ByteWidth, default 8: bits per byte-enable lane; minimum 1.
REQ-004 SHALL have parameter NumPorts, default 2: independent full read/write ports; minimum 1.
REQ-005 SHALL have parameter Latency, default 1: cycles from grant to earliest rvalid_o; minimum 1.
REQ-006 SHALL have parameter RespDepth, default Latency+1: maximum outstanding requests per port; minimum 1.
REQ-007 SHALL have parameter SimInit, default "none": array init "zeros", "ones", "random" or "none" (all X).
REQ-008 SHALL have dependent parameters AddrWidth = (NumWords>1) ? clog2(NumWords) : 1 and BeWidth = ceil(DataWidth/ByteWidth), not meant to be overridden.
REQ-009 SHALL have ports: clk_i  input  1  single clock, rising edge.
REQ-010 rst_i  input  1  reset, asynchronous, active-high.
REQ-011 req_i  input  NumPorts  request per port.
REQ-012 gnt_o  output  NumPorts  grant; request accepted when req_i and gnt_o are both high at a rising edge.
REQ-013 we_i  input  NumPorts  1 = write, 0 = read.
REQ-014 addr_i  input  NumPorts x AddrWidth  word address.
REQ-015 wdata_i  input  NumPorts x DataWidth  write data.
REQ-016 be_i  input  NumPorts x BeWidth  byte enable, active high.
REQ-017 rvalid_o  output  NumPorts  response valid.
REQ-018 rready_i  input  NumPorts  response ready; response consumed when rvalid_o and rready_i are high at an edge.
REQ-019 rdata_o  output  NumPorts x DataWidth  read data.
REQ-020 rerr_o  output  NumPorts  response error flag.

Function
REQ-021 Per port, an outstanding counter SHALL count accepted requests not yet consumed; gnt_o[i] = req_i[i] and (count < RespDepth), and SHALL NOT depend on rready_i.
REQ-022 Every accepted request, read or write, SHALL produce exactly one response, in acceptance order per port.
REQ-023 A read accepted at edge t SHALL return the array contents as they were before any write accepted at edge t, on any port.
REQ-024 The response for an accepted request SHALL be presented no earlier than Latency cycles after acceptance; with rready_i held high and an empty queue, it SHALL be presented exactly Latency cycles after acceptance.
REQ-025 Responses SHALL queue per port, up to RespDepth entries, while rready_i is low; none SHALL be dropped or reordered.
REQ-026 rvalid_o, rdata_o and rerr_o SHALL stay stable while rvalid_o is high and rready_i is low.
REQ-027 Write responses SHALL carry rdata_o = 0; rdata_o SHALL be 0 whenever rvalid_o is low.
REQ-028 A write SHALL update only the bits whose byte lane is enabled in be_i; be_i = 0 SHALL modify nothing but still produce a response.
REQ-029 On simultaneous writes to one address, ports SHALL apply in ascending index order, so the highest-index port wins per enabled byte.
REQ-030 With RespDepth >= Latency+1, rready_i held high and req_i held high, each port SHALL sustain one accepted request per cycle.
REQ-031 The outstanding counter SHALL handle an accept and a consume in the same cycle as net zero, and SHALL never exceed RespDepth or underflow.

Reset
REQ-032 While rst_i is high: every gnt_o, rvalid_o, rdata_o and rerr_o SHALL be 0; counters, pipelines and queues SHALL be empty; the array SHALL be loaded per SimInit.
REQ-033 Asserting rst_i mid-operation SHALL discard all in-flight and queued responses with no response emitted after release.
REQ-034 The first accept SHALL be possible at the first rising edge after rst_i deasserts.

Configuration
REQ-035 With macro TC_SRAM_HS_ADDR_CHECK_EN defined: a request with addr_i >= NumWords SHALL be granted normally, SHALL NOT modify the array, and SHALL respond with rerr_o = 1 and rdata_o = 0.
REQ-036 Without TC_SRAM_HS_ADDR_CHECK_EN: rerr_o SHALL be tied to 0 and no range check logic SHALL be generated; out-of-range access data is undefined.

Verification
REQ-037 Latency=2, RespDepth=3: write 0xAA..AA to addr 5 with all lanes enabled, then read addr 5 with rready_i=1 -> read rvalid_o exactly 2 cycles after its grant, rdata_o=0xAA..AA, rerr_o=0.
REQ-038 Hold rready_i=0 and keep req_i=1 on port 0 -> exactly 3 grants, then gnt_o=0; raise rready_i -> 3 responses in order, then grants resume.
REQ-039 Same cycle: port 0 writes 0x11 and port 1 writes 0x22 to addr 3, both all lanes -> a later read of addr 3 returns 0x22 in every byte.
REQ-040 Write 0xFF..FF, then write 0 with be_i=0b0001 -> a read returns 0xFF..FF00.
REQ-041 With 2 responses queued, pulse rst_i -> rvalid_o=0 immediately; no stale response after release; counter is 0.
REQ-042 Macro defined, NumWords=1000: write to addr 1000, then read addr 1000 -> both responses have rerr_o=1 and rdata_o=0; array unchanged.
